// File: rtl/seg_display_pkg.sv
// Shared types and active-low segment codes for the seven-segment display mux.
package seg_display_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 7;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] bcd_t;

    // Segment order {g,f,e,d,c,b,a}, a zero bit lights the segment.
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_display_mux_bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder with a blank override.
module bcd_to_seg
    import seg_display_pkg::*;
(
    input  logic             [3:0] bcd,
    input  logic                   blank,
    output logic [SEG_W-1:0]       seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        if (blank) begin
            seg_c = SEG_BLANK;
        end else begin
            case (bcd)
                4'd0:    seg_c = SEG_0;
                4'd1:    seg_c = SEG_1;
                4'd2:    seg_c = SEG_2;
                4'd3:    seg_c = SEG_3;
                4'd4:    seg_c = SEG_4;
                4'd5:    seg_c = SEG_5;
                4'd6:    seg_c = SEG_6;
                4'd7:    seg_c = SEG_7;
                4'd8:    seg_c = SEG_8;
                4'd9:    seg_c = SEG_9;
                default: seg_c = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg_display_mux.sv
// Four-digit time-multiplexed seven-segment driver with frame-coherent snapshot.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_display_mux
    import seg_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count0,
    input  logic [3:0] count1,
    input  logic [3:0] count2,
    input  logic [3:0] count3,
    input  logic       max_tick,
    input  logic       freeze,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned SLOT_W = $clog2(REFRESH_DIV);

    logic [SLOT_W-1:0] slot;
    digit_idx_t        digit;
    bcd_t              snap [NUM_DIGITS];
    logic              ovf;

    logic              slot_end_c;
    logic              load_c;
    logic              blank_c;
    logic              lz_c;
    bcd_t              cur_c;
    logic [SEG_W-1:0]  seg_c;

    assign slot_end_c = (slot == SLOT_W'(REFRESH_DIV - 1));
    assign load_c     = slot_end_c && (digit == 2'd3) && !freeze;
    assign blank_c    = (slot < SLOT_W'(BLANK_CYCLES));
    assign cur_c      = snap[digit];

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        lz_c = 1'b0;
        case (digit)
            2'd3:    lz_c = (snap[3] == 4'd0);
            2'd2:    lz_c = (snap[3] == 4'd0) && (snap[2] == 4'd0);
            2'd1:    lz_c = (snap[3] == 4'd0) && (snap[2] == 4'd0) && (snap[1] == 4'd0);
            default: lz_c = 1'b0;
        endcase
    end
`else
    assign lz_c = 1'b0;
`endif

    bcd_to_seg u_dec (
        .bcd   (cur_c),
        .blank (lz_c),
        .seg_c (seg_c)
    );

    // Slot counter and digit index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot  <= '0;
            digit <= 2'd0;
        end else if (slot_end_c) begin
            slot  <= '0;
            digit <= digit + 2'd1;
        end else begin
            slot  <= slot + SLOT_W'(1);
        end
    end

    // Snapshot reloads only at frame end so a value never tears across digits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= 4'd0;
        end else if (load_c) begin
            snap[0] <= count0;
            snap[1] <= count1;
            snap[2] <= count2;
            snap[3] <= count3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        ovf <= 1'b0;
        else if (max_tick) ovf <= 1'b1;
    end

    // Registered pin drivers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= 4'hF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (blank_c) begin
            an  <= 4'hF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << digit);
            seg <= seg_c;
            dp  <= !((digit == 2'd3) && ovf);
        end
    end

endmodule
